// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART transmit arbiter.
//   - default UART byte width, requester count and idle timeout
//   - FSM state encoding of the arbiter
//   - helpers deriving the grant-id and timeout-counter widths
package uart_pkg;

  localparam int UART_DATA_W  = 8;
  localparam int UART_NUM_REQ = 4;
  localparam int UART_TIMEOUT = 1024;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } uart_arb_state_t;

  // Grant id width; a single requester still gets a 1-bit id.
  function automatic int grant_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Timeout counter width; one spare bit above the limit.
  function automatic int tmo_w(input int timeout);
    return $clog2(timeout) + 1;
  endfunction

  localparam int UART_GRANT_W = grant_w(UART_NUM_REQ);
  localparam int UART_TMO_W   = tmo_w(UART_TIMEOUT);

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin winner search.
// Ports:
//   i_req_valid  per-requester valid
//   i_rr_ptr     last granted requester; search starts one above it
//   o_winner     first valid requester found from (i_rr_ptr+1) upward, wrapping
//   o_any_valid  any requester valid
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int P_NUM_REQ = UART_NUM_REQ
) (
  input  logic [P_NUM_REQ-1:0]          i_req_valid,
  input  logic [grant_w(P_NUM_REQ)-1:0] i_rr_ptr,
  output logic [grant_w(P_NUM_REQ)-1:0] o_winner,
  output logic                          o_any_valid
);

  localparam int GW = grant_w(P_NUM_REQ);

  // cand_id[j] is the requester at search position j; rot_valid[j] its valid.
  logic [GW-1:0]        cand_id [P_NUM_REQ];
  logic [P_NUM_REQ-1:0] rot_valid;

  genvar gi;
  generate
    for (gi = 0; gi < P_NUM_REQ; gi++) begin : g_cand
      assign cand_id[gi]   = GW'((int'(i_rr_ptr) + 1 + gi) % P_NUM_REQ);
      assign rot_valid[gi] = i_req_valid[cand_id[gi]];
    end
  endgenerate

  // Scan from the far end so the nearest valid position overwrites last.
  always_comb begin
    o_winner = '0;
    for (int j = P_NUM_REQ - 1; j >= 0; j--) begin
      if (rot_valid[j]) begin
        o_winner = cand_id[j];
      end
    end
  end

  assign o_any_valid = |i_req_valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter feeding one UART transmitter.
// One packet is in flight at a time; bytes move through a single output register.
// Ports:
//   i_clk, w_user_rst  clock; asynchronous active-high reset
//   i_req_valid/data/last, o_req_ready  per-requester byte stream
//   o_tx_data, o_tx_valid, i_tx_ready   byte stream to the UART transmitter
//   o_grant_id  current or last granted requester
//   o_busy      high while a packet is granted
//   o_timeout   one-cycle pulse when a stalled packet is aborted
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int P_NUM_REQ    = UART_NUM_REQ,
  parameter int P_DATA_WIDTH = UART_DATA_W,
  parameter int P_TIMEOUT    = UART_TIMEOUT
) (
  input  logic                              i_clk,
  input  logic                              w_user_rst,
  input  logic [P_NUM_REQ-1:0]              i_req_valid,
  input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] i_req_data,
  input  logic [P_NUM_REQ-1:0]              i_req_last,
  output logic [P_NUM_REQ-1:0]              o_req_ready,
  output logic [P_DATA_WIDTH-1:0]           o_tx_data,
  output logic                              o_tx_valid,
  input  logic                              i_tx_ready,
  output logic [grant_w(P_NUM_REQ)-1:0]     o_grant_id,
  output logic                              o_busy,
  output logic                              o_timeout
);

  localparam int GW = grant_w(P_NUM_REQ);
  localparam int TW = tmo_w(P_TIMEOUT);

  uart_arb_state_t   state_q, state_d;
  logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic              tx_valid_q, tx_valid_d;
  logic [P_DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic              last_q, last_d;
  logic              timeout_q, timeout_d;
  logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;

  logic [P_DATA_WIDTH-1:0] req_byte [P_NUM_REQ];
  logic [GW-1:0]     pick_id;
  logic              pick_any;
  logic              xfer_open;
  logic              g_valid, g_last;
  logic              accept, tx_hs, idle_tick;

  // The granted requester may hand over a byte only while the output register is empty.
  assign xfer_open = (state_q == S_XFER) && !tx_valid_q;

  genvar gi;
  generate
    for (gi = 0; gi < P_NUM_REQ; gi++) begin : g_req
      assign req_byte[gi]    = i_req_data[gi*P_DATA_WIDTH +: P_DATA_WIDTH];
      assign o_req_ready[gi] = xfer_open && (grant_q == GW'(gi));
    end
  endgenerate

  assign g_valid   = i_req_valid[grant_q];
  assign g_last    = i_req_last[grant_q];
  assign accept    = xfer_open && g_valid;
  assign tx_hs     = tx_valid_q && i_tx_ready;
  // Only the granted requester's silence is counted, never a downstream stall.
  assign idle_tick = xfer_open && !g_valid;

  uart_rr_pick #(
    .P_NUM_REQ (P_NUM_REQ)
  ) u_rr_pick (
    .i_req_valid (i_req_valid),
    .i_rr_ptr    (rr_ptr_q),
    .o_winner    (pick_id),
    .o_any_valid (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    last_d     = last_q;
    timeout_d  = 1'b0;
    tmo_cnt_d  = tmo_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          grant_d   = pick_id;
          state_d   = S_XFER;
          tmo_cnt_d = '0;
        end
      end
      S_XFER: begin
        // accept, tx_hs and idle_tick are mutually exclusive via tx_valid_q.
        if (accept) begin
          tx_valid_d = 1'b1;
          tx_data_d  = req_byte[grant_q];
          last_d     = g_last;
          tmo_cnt_d  = '0;
        end else if (tx_hs) begin
          tx_valid_d = 1'b0;
          // Ending a packet always passes through S_IDLE, so no same-cycle regrant.
          if (last_q) begin
            rr_ptr_d = grant_q;
            state_d  = S_IDLE;
          end
        end else if (idle_tick) begin
          if (tmo_cnt_q == TW'(P_TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            rr_ptr_d  = grant_q;
            state_d   = S_IDLE;
            tmo_cnt_d = '0;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge w_user_rst) begin
    if (w_user_rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= GW'(P_NUM_REQ - 1);  // requester 0 is searched first
      grant_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      last_q     <= 1'b0;
      timeout_q  <= 1'b0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      last_q     <= last_d;
      timeout_q  <= timeout_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
  assign o_grant_id = grant_q;
  assign o_busy     = (state_q == S_XFER);
  assign o_timeout  = timeout_q;

endmodule
